// File: rtl/branch_compare_mc_if.sv
// Handshake and result bundle for the multi-cycle branch comparator.
// The producer drives operands and out_ready; the comparator drives the rest.
interface branch_compare_mc_if #(
  parameter int WIDTH = 32
);
  // A transfer happens on a rising edge where valid && ready. The sender holds
  // its payload stable while valid is high and ready is low.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] rs1_out;
  logic [WIDTH-1:0] rs2_out;
  logic             cmpop;
  logic [2:0]       funct3;
  logic             out_valid;
  logic             out_ready;
  logic             br_eq;
  logic             br_lt;
  logic             br_taken;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output in_valid, rs1_out, rs2_out, cmpop, funct3, out_ready,
    input  in_ready, out_valid, br_eq, br_lt, br_taken, busy, dbg_state
  );

  modport slave (
    input  in_valid, rs1_out, rs2_out, cmpop, funct3, out_ready,
    output in_ready, out_valid, br_eq, br_lt, br_taken, busy, dbg_state
  );
endinterface

// File: rtl/branch_compare_mc.sv
// Multi-cycle branch comparator: CHUNK bits per cycle, MSB chunk first.
// Define BRCMP_EARLY_EXIT_EN to stop at the first differing chunk; otherwise latency is always NCHUNK.
module branch_compare_mc #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic               clk,
  input logic               rst,
  branch_compare_mc_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("branch_compare_mc: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CMP  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cmpop;
  logic [2:0]       r_funct3;
  logic             r_eq;
  logic             r_lt;
  logic             r_taken;

  logic [CHUNK-1:0] w_a;
  logic [CHUNK-1:0] w_b;
  logic             w_top;
  logic             w_ne;
  logic             w_lt;

  assign w_a   = r_a[int'(r_idx)*CHUNK +: CHUNK];
  assign w_b   = r_b[int'(r_idx)*CHUNK +: CHUNK];
  assign w_top = (r_idx == IW'(NCHUNK - 1));
  assign w_ne  = (w_a != w_b);
  // Only the top chunk carries the sign; lower chunks always compare unsigned.
  assign w_lt  = (w_top && r_cmpop && (w_a[CHUNK-1] != w_b[CHUNK-1])) ?
                 w_a[CHUNK-1] : (w_a < w_b);

  function automatic logic f_taken(input logic eq, input logic lt, input logic [2:0] f3);
    case (f3)
      3'b000:         f_taken = eq;
      3'b001:         f_taken = !eq;
      3'b100, 3'b110: f_taken = lt;
      3'b101, 3'b111: f_taken = !lt;
      default:        f_taken = 1'b0;
    endcase
  endfunction

`ifndef BRCMP_EARLY_EXIT_EN
  logic r_found;
  logic r_lt_found;
  logic w_found_n;
  logic w_lt_n;

  assign w_found_n = r_found | w_ne;
  assign w_lt_n    = r_found ? r_lt_found : w_lt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cmpop  <= 1'b0;
      r_funct3 <= 3'b000;
      r_eq     <= 1'b0;
      r_lt     <= 1'b0;
      r_taken  <= 1'b0;
`ifndef BRCMP_EARLY_EXIT_EN
      r_found    <= 1'b0;
      r_lt_found <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a      <= bus.rs1_out;
            r_b      <= bus.rs2_out;
            r_cmpop  <= bus.cmpop;
            r_funct3 <= bus.funct3;
            r_idx    <= IW'(NCHUNK - 1);
            r_state  <= S_CMP;
`ifndef BRCMP_EARLY_EXIT_EN
            r_found    <= 1'b0;
            r_lt_found <= 1'b0;
`endif
          end
        end
        S_CMP: begin
`ifdef BRCMP_EARLY_EXIT_EN
          if (w_ne) begin
            r_eq    <= 1'b0;
            r_lt    <= w_lt;
            r_taken <= f_taken(1'b0, w_lt, r_funct3);
            r_state <= S_DONE;
          end else if (r_idx == '0) begin
            r_eq    <= 1'b1;
            r_lt    <= 1'b0;
            r_taken <= f_taken(1'b1, 1'b0, r_funct3);
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
`else
          // Latch the first difference but keep walking for constant latency.
          if (!r_found && w_ne) begin
            r_found    <= 1'b1;
            r_lt_found <= w_lt;
          end
          if (r_idx == '0) begin
            r_eq    <= !w_found_n;
            r_lt    <= w_found_n & w_lt_n;
            r_taken <= f_taken(!w_found_n, w_found_n & w_lt_n, r_funct3);
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
`endif
        end
        S_DONE: begin
          if (bus.out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.br_eq     = r_eq;
  assign bus.br_lt     = r_lt;
  assign bus.br_taken  = r_taken;
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_branch_compare_mc.sv
// Bench for branch_compare_mc (WIDTH=32, CHUNK=8): vector table, random vectors,
// and hand-written reset/backpressure sequences, checked through an expected queue.
module tb_branch_compare_mc;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  branch_compare_mc_if #(.WIDTH(32)) bus ();

  branch_compare_mc #(.WIDTH(32), .CHUNK(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cmpop;
    logic [2:0]  funct3;
    logic [2:0]  exp_res;  // {eq, lt, taken}
    int          stall;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [2:0] exp_q[$];
  int         lat_q[$];
  vec_t       vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model_res(input logic [31:0] a, input logic [31:0] b,
                                           input logic c, input logic [2:0] f3);
    logic eq, lt, tk;
    eq = (a == b);
    lt = c ? ($signed(a) < $signed(b)) : (a < b);
    case (f3)
      3'b000:         tk = eq;
      3'b001:         tk = !eq;
      3'b100, 3'b110: tk = lt;
      3'b101, 3'b111: tk = !lt;
      default:        tk = 1'b0;
    endcase
    return {eq, lt, tk};
  endfunction

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef BRCMP_EARLY_EXIT_EN
    logic [31:0] x;
    x = a ^ b;
    if (x[31:24] != 0) return 1;
    if (x[23:16] != 0) return 2;
    if (x[15:8]  != 0) return 3;
    return 4;
`else
    return (a == b) ? 4 : 4;
`endif
  endfunction

  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic c,
                         input logic [2:0] f3, input logic [2:0] exp_res, input int stall);
    int waited;
    int lat;
    logic seen;
    logic [2:0] e;
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_before_accept", {31'b0, bus.in_ready}, 32'd1);
    bus.rs1_out  = a;
    bus.rs2_out  = b;
    bus.cmpop    = c;
    bus.funct3   = f3;
    bus.in_valid = 1'b1;
    exp_q.push_back(exp_res);
    lat_q.push_back(model_lat(a, b));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.rs1_out  = $urandom;
    bus.rs2_out  = $urandom;
    bus.cmpop    = ~c;
    bus.funct3   = 3'($urandom_range(0, 7));
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      seen = bus.out_valid;
    end
    check("out_valid_seen", {31'b0, seen}, 32'd1);
    e = exp_q.pop_front();
    check("latency", lat, lat_q.pop_front());
    check("result_eq_lt_taken", {29'b0, bus.br_eq, bus.br_lt, bus.br_taken}, {29'b0, e});
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid_inready", {30'b0, bus.out_valid, bus.in_ready}, 32'b10);
      check("stall_result_hold", {29'b0, bus.br_eq, bus.br_lt, bus.br_taken}, {29'b0, e});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("after_release_ready_valid_busy",
          {29'b0, bus.in_ready, bus.out_valid, bus.busy}, 32'b100);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    logic        c;
    logic [2:0]  f3;
    bit          ov_seen;

    vecs[0] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 3'b110, 3'b011, 0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100, 3'b011, 0};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b110, 3'b000, 0};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 3'b000, 3'b101, 0};
    vecs[4] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 3'b001, 3'b100, 3};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 3'b011, 3'b100, 0};
    vecs[6] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 3'b111, 3'b010, 1};
    vecs[7] = '{32'h0001_0000, 32'h0002_0000, 1'b1, 3'b100, 3'b011, 0};
    vecs[8] = '{32'h0000_0080, 32'h0000_007F, 1'b1, 3'b110, 3'b000, 0};
    vecs[9] = '{32'h0000_0300, 32'h0000_0200, 1'b0, 3'b010, 3'b000, 2};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.rs1_out   = '0;
    bus.rs2_out   = '0;
    bus.cmpop     = 1'b0;
    bus.funct3    = 3'b000;

    repeat (3) @(negedge clk);
    check("in_ready_during_reset", {31'b0, bus.in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("reset_outputs",
          {26'b0, bus.in_ready, bus.out_valid, bus.busy, bus.br_eq, bus.br_lt, bus.br_taken},
          32'b100000);

    for (int i = 0; i < 10; i++)
      run_txn(vecs[i].a, vecs[i].b, vecs[i].cmpop, vecs[i].funct3, vecs[i].exp_res, vecs[i].stall);

    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = a;
      if ($urandom_range(0, 3) != 0) begin
        int k;
        k = $urandom_range(0, 3);
        b[8*k +: 8] = 8'($urandom_range(0, 255));
      end
      c  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      run_txn(a, b, c, f3, model_res(a, b, c, f3), $urandom_range(0, 2));
    end

    // Reset while comparing: transaction must vanish.
    @(negedge clk);
    bus.rs1_out  = 32'h0000_0001;
    bus.rs2_out  = 32'h0000_0002;
    bus.cmpop    = 1'b0;
    bus.funct3   = 3'b100;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("busy_before_mid_reset", {31'b0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_outputs",
          {26'b0, bus.in_ready, bus.out_valid, bus.busy, bus.br_eq, bus.br_lt, bus.br_taken},
          32'b0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    ov_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen = 1'b1;
    end
    bus.out_ready = 1'b0;
    check("no_out_valid_after_abort", {31'b0, ov_seen}, 32'd0);
    check("idle_after_abort", {30'b0, bus.in_ready, bus.busy}, 32'b10);

    run_txn(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 3'b101, 3'b010, 0);

    // in_valid together with rst: nothing captured.
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.rs1_out  = 32'h0000_0001;
    bus.rs2_out  = 32'h0000_0009;
    @(posedge clk);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("valid_with_reset_not_captured", {30'b0, bus.busy, bus.in_ready}, 32'b01);

    run_txn(32'hFFFF_FF00, 32'hFFFF_FF01, 1'b1, 3'b110, 3'b011, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
